// File: rtl/ci_dispatch_pkg.sv
// Shared types and constants for the custom-instruction dispatcher.
package ci_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int          NUM_UNITS       = 4;
  localparam logic [31:0] TIMEOUT_RESULT  = 32'hFFFF_FFFF;
  localparam logic [31:0] UNMAPPED_RESULT = 32'h0000_0000;

  // One-hot start vector for the selected unit.
  function automatic logic [NUM_UNITS-1:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/ci_timeout_timer.sv
// Watchdog counter: cleared while a start is issued, counts while waiting,
// and flags the cycle in which the wait budget is exhausted.
module ci_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [15:0] TERMINAL_COUNT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_r;

  // Wait-cycle counter; clear has priority over counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else if (enable) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign terminal = (count_r == TERMINAL_COUNT);

endmodule

// File: rtl/ci_dispatcher.sv
// Routes CPU custom instructions to one of four CI units, waits for the
// selected unit's done (bounded by a watchdog) and returns its result.
module ci_dispatcher
  import ci_dispatch_pkg::*;
#(
  parameter logic [31:0] UNIT_IDS       = 32'h03020100,
  parameter logic [3:0]  UNIT_MASK      = 4'hF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpuStart,
  input  logic [7:0]   cpuCiN,
  input  logic [31:0]  cpuValueA,
  input  logic [31:0]  cpuValueB,
  output logic         cpuDone,
  output logic [31:0]  cpuResult,
  output logic [3:0]   unitStart,
  output logic [31:0]  unitValueA,
  output logic [31:0]  unitValueB,
  output logic [7:0]   unitCiN,
  input  logic [3:0]   unitDone,
  input  logic [127:0] unitResult,
  output logic         timeoutFlag,
  output logic         busy
);

  state_e      state_r;
  logic [1:0]  sel_r;
  logic        cpu_done_r;
  logic [31:0] cpu_result_r;
  logic [3:0]  unit_start_r;
  logic [31:0] value_a_r;
  logic [31:0] value_b_r;
  logic [7:0]  ci_n_r;
  logic        timeout_flag_r;
  logic        busy_r;

  logic [3:0]  match_s;
  logic        hit_s;
  logic [1:0]  hit_sel_s;
  logic        sel_done_s;
  logic [31:0] sel_result_s;
  logic        terminal_s;

  // Decode the incoming CI number; lowest attached unit wins on duplicate IDs.
  always_comb begin
    match_s   = 4'b0000;
    hit_sel_s = 2'd0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      match_s[k] = UNIT_MASK[k] & (cpuCiN == UNIT_IDS[8*k +: 8]);
    end
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (match_s[k]) begin
        hit_sel_s = 2'(k);
      end else begin
        hit_sel_s = hit_sel_s;
      end
    end
  end

  assign hit_s        = |match_s;
  assign sel_done_s   = unitDone[sel_r];
  assign sel_result_s = unitResult[{sel_r, 5'd0} +: 32];

  ci_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (state_r == ST_ISSUE),
    .enable   (state_r == ST_WAIT),
    .terminal (terminal_s)
  );

  // Dispatch FSM; all CPU- and unit-facing outputs are registered here.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      sel_r          <= 2'd0;
      cpu_done_r     <= 1'b0;
      cpu_result_r   <= 32'h0000_0000;
      unit_start_r   <= 4'b0000;
      value_a_r      <= 32'h0000_0000;
      value_b_r      <= 32'h0000_0000;
      ci_n_r         <= 8'h00;
      timeout_flag_r <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cpu_done_r   <= 1'b0;
          cpu_result_r <= 32'h0000_0000;
          unit_start_r <= 4'b0000;
          if (cpuStart) begin
            value_a_r <= cpuValueA;
            value_b_r <= cpuValueB;
            ci_n_r    <= cpuCiN;
            busy_r    <= 1'b1;
            if (hit_s) begin
              sel_r        <= hit_sel_s;
              unit_start_r <= sel_onehot(hit_sel_s);
              state_r      <= ST_ISSUE;
            end else begin
              cpu_done_r   <= 1'b1;
              cpu_result_r <= UNMAPPED_RESULT;
              state_r      <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          unit_start_r <= 4'b0000;
          if (sel_done_s) begin
            cpu_done_r   <= 1'b1;
            cpu_result_r <= sel_result_s;
            state_r      <= ST_RESP;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A real done beats a simultaneous timeout.
          if (sel_done_s) begin
            cpu_done_r   <= 1'b1;
            cpu_result_r <= sel_result_s;
            state_r      <= ST_RESP;
          end else if (terminal_s) begin
            cpu_done_r     <= 1'b1;
            cpu_result_r   <= TIMEOUT_RESULT;
            timeout_flag_r <= 1'b1;
            state_r        <= ST_RESP;
          end
        end
        ST_RESP: begin
          cpu_done_r   <= 1'b0;
          cpu_result_r <= 32'h0000_0000;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          cpu_done_r   <= 1'b0;
          cpu_result_r <= 32'h0000_0000;
          unit_start_r <= 4'b0000;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpuDone     = cpu_done_r;
  assign cpuResult   = cpu_result_r;
  assign unitStart   = unit_start_r;
  assign unitValueA  = value_a_r;
  assign unitValueB  = value_b_r;
  assign unitCiN     = ci_n_r;
  assign timeoutFlag = timeout_flag_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ci_dispatcher.sv
// Directed bench for ci_dispatcher with a watchdog budget of 8 cycles.
module tb_ci_dispatcher;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cpuStart = 1'b0;
  logic [7:0]   cpuCiN = 8'h00;
  logic [31:0]  cpuValueA = 32'h0;
  logic [31:0]  cpuValueB = 32'h0;
  logic         cpuDone;
  logic [31:0]  cpuResult;
  logic [3:0]   unitStart;
  logic [31:0]  unitValueA;
  logic [31:0]  unitValueB;
  logic [7:0]   unitCiN;
  logic [3:0]   unitDone = 4'b0000;
  logic [127:0] unitResult = 128'h0;
  logic         timeoutFlag;
  logic         busy;

  int n_vec = 0;
  int n_miscmp = 0;

  ci_dispatcher #(
    .UNIT_IDS       (32'h03020100),
    .UNIT_MASK      (4'hF),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cpuStart    (cpuStart),
    .cpuCiN      (cpuCiN),
    .cpuValueA   (cpuValueA),
    .cpuValueB   (cpuValueB),
    .cpuDone     (cpuDone),
    .cpuResult   (cpuResult),
    .unitStart   (unitStart),
    .unitValueA  (unitValueA),
    .unitValueB  (unitValueB),
    .unitCiN     (unitCiN),
    .unitDone    (unitDone),
    .unitResult  (unitResult),
    .timeoutFlag (timeoutFlag),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_vec({tag, "_unitStart"}, 32'(unitStart), 32'h0);
    check_vec({tag, "_cpuDone"}, 32'(cpuDone), 32'h0);
    check_vec({tag, "_busy"}, 32'(busy), 32'h0);
    check_vec({tag, "_timeoutFlag"}, 32'(timeoutFlag), 32'h0);
    check_vec({tag, "_cpuResult"}, cpuResult, 32'h0);
    check_vec({tag, "_unitValueA"}, unitValueA, 32'h0);
    check_vec({tag, "_unitValueB"}, unitValueB, 32'h0);
    check_vec({tag, "_unitCiN"}, 32'(unitCiN), 32'h0);
  endtask

  // Issue one request at cycle 0 and model the responding unit.
  // u < 0 means no unit ever responds; unit u raises done at cycle 1+n.
  // noise injects a stray unitDone[0] and a second cpuStart at cycle 3.
  task automatic run_req(input string tag, input logic [7:0] ci, input logic [31:0] a,
                         input logic [31:0] b, input int u, input int n,
                         input logic [31:0] res, input bit noise,
                         input logic [3:0] exp_start, input int exp_start_cyc,
                         input int exp_done_cyc, input logic [31:0] exp_res,
                         input logic exp_flag);
    int          start_cyc = -1;
    int          done_cyc  = -1;
    int          done_cnt  = 0;
    int          zero_bad  = 0;
    logic [3:0]  start_val = 4'b0000;
    logic [31:0] done_res  = 32'h0;
    logic [31:0] held_a    = 32'h0;
    logic [31:0] held_b    = 32'h0;
    logic [7:0]  held_ci   = 8'h00;
    logic        flag_end  = 1'b0;
    logic        busy1     = 1'b0;
    cpuStart  = 1'b1;
    cpuCiN    = ci;
    cpuValueA = a;
    cpuValueB = b;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      cpuStart = 1'b0;
      unitDone = 4'b0000;
      if (u >= 0 && cyc == 1 + n) begin
        unitDone[u] = 1'b1;
        unitResult[32*u +: 32] = res;
      end
      if (noise && cyc == 3) begin
        unitDone[0]       = 1'b1;
        unitResult[31:0]  = 32'hDEAD_BEEF;
        cpuStart          = 1'b1;
        cpuCiN            = 8'h00;
        cpuValueA         = 32'h1111_1111;
        cpuValueB         = 32'h2222_2222;
      end
      if (cyc == 1) busy1 = busy;
      if (unitStart != 4'b0000 && start_cyc < 0) begin
        start_cyc = cyc;
        start_val = unitStart;
      end
      if (cpuDone) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          done_res = cpuResult;
          held_a   = unitValueA;
          held_b   = unitValueB;
          held_ci  = unitCiN;
          flag_end = timeoutFlag;
        end
      end else if (cpuResult != 32'h0) begin
        zero_bad++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    unitDone = 4'b0000;
    check_vec({tag, "_start_val"}, 32'(start_val), 32'(exp_start));
    check_vec({tag, "_start_cyc"}, 32'(start_cyc), 32'(exp_start_cyc));
    check_vec({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done_cyc));
    check_vec({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check_vec({tag, "_result"}, done_res, exp_res);
    check_vec({tag, "_held_a"}, held_a, a);
    check_vec({tag, "_held_b"}, held_b, b);
    check_vec({tag, "_held_ci"}, 32'(held_ci), 32'(ci));
    check_vec({tag, "_flag"}, 32'(flag_end), 32'(exp_flag));
    check_vec({tag, "_busy_c1"}, 32'(busy1), 32'h1);
    check_vec({tag, "_busy_end"}, 32'(busy), 32'h0);
    check_vec({tag, "_idle_result"}, 32'(zero_bad), 32'h0);
  endtask

  initial begin
    int late_done;
    // Reset state.
    #12;
    check_all_zero("rst");
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();

    run_req("map_delay", 8'h01, 32'h0000_000A, 32'h0000_000B, 1, 3, 32'h0000_1234, 1'b0,
            4'b0010, 1, 5, 32'h0000_1234, 1'b0);
    run_req("comb_done", 8'h02, 32'h1234_5678, 32'h9ABC_DEF0, 2, 0, 32'hA5A5_A5A5, 1'b0,
            4'b0100, 1, 2, 32'hA5A5_A5A5, 1'b0);
    run_req("unmapped", 8'h7F, 32'hCAFE_BABE, 32'h0BAD_F00D, -1, 0, 32'h0, 1'b0,
            4'b0000, -1, 1, 32'h0000_0000, 1'b0);
    run_req("timeout", 8'h00, 32'h0000_0001, 32'h0000_0002, -1, 0, 32'h0, 1'b0,
            4'b0001, 1, 10, 32'hFFFF_FFFF, 1'b1);
    run_req("noise_u3", 8'h03, 32'h3333_0003, 32'h4444_0004, 3, 4, 32'h0000_0042, 1'b1,
            4'b1000, 1, 6, 32'h0000_0042, 1'b1);

    // Reset during WAIT abandons the transaction.
    cpuStart  = 1'b1;
    cpuCiN    = 8'h01;
    cpuValueA = 32'h5555_5555;
    cpuValueB = 32'h6666_6666;
    tick();
    cpuStart = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("rst_wait");
    late_done = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpuDone) late_done++;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpuDone) late_done++;
    end
    check_vec("rst_no_done", 32'(late_done), 32'h0);
    check_vec("rst_busy_after", 32'(busy), 32'h0);

    run_req("post_rst", 8'h01, 32'h0000_0077, 32'h0000_0088, 1, 1, 32'hCAFE_0001, 1'b0,
            4'b0010, 1, 3, 32'hCAFE_0001, 1'b0);
    run_req("unit0", 8'h00, 32'h0000_0099, 32'h0000_00AA, 0, 2, 32'h0BEE_0000, 1'b0,
            4'b0001, 1, 4, 32'h0BEE_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/ci_dispatcher.md
# ci_dispatcher

Sequencer that sits between the CPU custom-instruction port and up to four custom-instruction units (profile counter, accelerators) sharing the CI bus. Decodes `ciN` against per-unit IDs, issues a one-cycle start to the selected unit with registered operands, waits for its `done`, and returns the result to the CPU. Adds a timeout watchdog so an unmapped or hung unit never stalls the pipeline.

## Interface
Parameters:
- `UNIT_IDS`, 32'h03020100: four packed 8-bit custom IDs; unit k uses `UNIT_IDS[8k+7:8k]`.
- `UNIT_MASK`, 4'hF: bit k set means unit k is attached. Unattached units never match.
- `TIMEOUT_CYCLES`, 255: maximum cycles to wait for `unitDone`. Legal range 1..65535.

Ports:
- `clock`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpuStart`  in  1  one-cycle CI request pulse from the CPU.
- `cpuCiN`  in  8  custom-instruction number.
- `cpuValueA`, `cpuValueB`  in  32 each  CI operands.
- `cpuDone`  out  1  one-cycle completion pulse.
- `cpuResult`  out  32  result; valid only while `cpuDone`=1, 0 otherwise.
- `unitStart`  out  4  one-hot start pulse to unit k.
- `unitValueA`, `unitValueB`  out  32 each  registered operands, broadcast to all units.
- `unitCiN`  out  8  registered `cpuCiN`, broadcast.
- `unitDone`  in  4  done from unit k.
- `unitResult`  in  128  packed results; unit k uses `[32k+31:32k]`.
- `timeoutFlag`  out  1  sticky; set on any timeout, cleared only by reset.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: on `cpuStart`, register `cpuCiN` and the operands, then decode.
  - Match (lowest k wins on duplicate IDs): latch sel=k and go to ISSUE.
  - No match: go to RESP with result 0 (unmapped).
- ISSUE: drive `unitStart[sel]`=1 for exactly this cycle and clear the timeout counter.
  - If `unitDone[sel]`=1 in this same cycle, capture `unitResult[sel]` and go to RESP.
  - Otherwise go to WAIT.
- WAIT: count cycles (counter width 16).
  - If `unitDone[sel]`=1, capture the result and go to RESP.
  - Else if count = `TIMEOUT_CYCLES`-1, capture 32'hFFFF_FFFF, set `timeoutFlag`, go to RESP.
  - `unitDone` arriving in the same cycle as the timeout takes priority: the real result is captured.
- RESP: `cpuDone`=1 and `cpuResult`=captured value, then go to IDLE.
- Ignored inputs:
  - `unitDone` from non-selected units, in all states.
  - `cpuStart` while `busy`; the CPU contract is to stall until `cpuDone`.
- Operand registers hold their value from ISSUE through RESP. They are updated only on an accepted `cpuStart`.
- Reset (async assert, synchronous deassert handled externally): FSM to IDLE. Outputs in reset:
  - `unitStart`, `cpuDone`, `busy`, `timeoutFlag` = 0.
  - `cpuResult`, `unitValueA`, `unitValueB`, `unitCiN` = 0.
  - Reset mid-transaction abandons it; no `cpuDone` is produced.

## Timing
- All outputs are registered.
- Mapped request, `cpuStart` at cycle 0:
  - `unitStart[sel]` at cycle 1.
  - Unit asserts `unitDone` at cycle 1+n (n≥0).
  - `cpuDone` at cycle 2+n. Minimum latency is 2 cycles.
- Unmapped request: `cpuDone` at cycle 1 with result 0.
- Timeout: `cpuDone` at cycle 1+`TIMEOUT_CYCLES`+1. `timeoutFlag` rises in the same cycle as that `cpuDone`.
- Back-to-back requests: next `cpuStart` is accepted in the cycle after RESP (IDLE). Throughput is one request per 3 cycles minimum.

## Structure
- Package `ci_dispatch_pkg`:
  - state enum (IDLE, ISSUE, WAIT, RESP);
  - `TIMEOUT_RESULT` = 32'hFFFF_FFFF;
  - `UNMAPPED_RESULT` = 32'h0;
  - `NUM_UNITS` = 4.
- Sub-module `ci_timeout_timer`: 16-bit counter with clear, enable and a terminal-count output compared against `TIMEOUT_CYCLES`-1.
- ID decode and result mux stay inline.

## Test plan
- `cpuCiN`=8'h01, unit 1 raises `unitDone` 3 cycles after its start with result 32'h0000_1234 -> `unitStart`=4'b0010 at cycle 1, `cpuDone` at cycle 5 with 32'h0000_1234, `timeoutFlag`=0.
- `cpuCiN`=8'h02, unit 2 has combinational done in the ISSUE cycle with result 32'hA5A5_A5A5 -> `cpuDone` at cycle 2 with 32'hA5A5_A5A5.
- `cpuCiN`=8'h7F (unmapped) -> no `unitStart`, `cpuDone` at cycle 1 with 0.
- `TIMEOUT_CYCLES`=8, unit 0 never responds -> `cpuDone` at cycle 10 with 32'hFFFF_FFFF, `timeoutFlag` stays 1 through the following successful request.
- While waiting on unit 3:
  - `unitDone[0]` pulse -> ignored;
  - second `cpuStart` -> ignored;
  - `unitDone[3]` with 32'h0000_0042 -> single `cpuDone` with 32'h0000_0042.
- `reset` driven low during WAIT -> all outputs 0 immediately, no `cpuDone`; after release, a new request completes normally.
